// File: rtl/blink_game_ctrl.sv
// Blink reaction-game sequencer: arms a countdown, sweeps a lit LED, judges hits
// against the last LED and drives the external loss-detector flop.
module blink_game_ctrl #(
  parameter int TICK_DIV  = 25000000,
  parameter int N_LEDS    = 8,
  parameter int WIN_HITS  = 8,
  parameter int ARM_TICKS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hit,
  input  logic              lose,
  output logic              dec_d,
  output logic              dec_enable,
  output logic              dec_rst,
  output logic [N_LEDS-1:0] led,
  output logic [3:0]        score,
  output logic              game_over,
  output logic              won
);

  // state | meaning
  // IDLE  | waiting for start, LEDs dark
  // ARM   | countdown blink before play
  // PLAY  | LED sweep, hits judged
  // CHECK | one cycle to read the detector's lose flag
  // LOST  | game over, all LEDs lit
  // WON   | win pattern shown
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARM   = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] LOST  = 3'd4;
  localparam logic [2:0] WON   = 3'd5;

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = $clog2(N_LEDS);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  TARGET    = IDX_W'(N_LEDS - 1);
  localparam logic [3:0]        ARM_LAST  = 4'(ARM_TICKS - 1);
  localparam logic [3:0]        WIN_SCORE = 4'(WIN_HITS);
  localparam logic [N_LEDS-1:0] ONES      = '1;
  localparam logic [N_LEDS-1:0] ONE       = N_LEDS'(1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        arm_cnt;
  logic [IDX_W-1:0]  led_idx;
  logic [IDX_W-1:0]  idx_next;
  logic              hit_ok;
  logic              tick;
  logic              at_target;
  logic              pass;
  logic [N_LEDS-1:0] alt_pat;

  for (genvar i = 0; i < N_LEDS; i++) begin : g_alt
    assign alt_pat[i] = (i % 2) == 1;
  end

  assign tick      = ((state == ARM) || (state == PLAY)) && (cnt == CNT_LAST);
  assign at_target = (led_idx == TARGET);
  assign idx_next  = led_idx + 1'b1;
  // a hit landing on the closing tick still counts for this window
  assign pass      = hit_ok | hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      arm_cnt    <= '0;
      led_idx    <= '0;
      hit_ok     <= 1'b0;
      led        <= '0;
      score      <= '0;
      dec_d      <= 1'b0;
      dec_enable <= 1'b0;
      dec_rst    <= 1'b0;
      game_over  <= 1'b0;
      won        <= 1'b0;
    end else begin
      dec_enable <= 1'b0;
      dec_rst    <= 1'b0;

      if ((state == ARM) || (state == PLAY))
        cnt <= tick ? '0 : cnt + 1'b1;
      else if (state != CHECK)
        cnt <= '0;

      case (state)
        IDLE, LOST, WON: begin
          if (start) begin
            state     <= ARM;
            dec_rst   <= 1'b1;
            score     <= '0;
            arm_cnt   <= '0;
            led_idx   <= '0;
            hit_ok    <= 1'b0;
            led       <= ONES;
            game_over <= 1'b0;
            won       <= 1'b0;
          end
        end
        ARM: begin
          if (tick) begin
            if (arm_cnt == ARM_LAST) begin
              state   <= PLAY;
              led_idx <= '0;
              hit_ok  <= 1'b0;
              led     <= ONE;
            end else begin
              arm_cnt <= arm_cnt + 1'b1;
              led     <= arm_cnt[0] ? ONES : '0;
            end
          end
        end
        PLAY: begin
          if (hit && !at_target) begin
            dec_d      <= 1'b0;
            dec_enable <= 1'b1;
            state      <= CHECK;
          end else if (tick && at_target) begin
            dec_d      <= pass;
            dec_enable <= 1'b1;
            if (pass && (score != WIN_SCORE))
              score <= score + 1'b1;
            hit_ok  <= 1'b0;
            led_idx <= '0;
            led     <= ONE;
            state   <= CHECK;
          end else if (tick) begin
            led_idx <= idx_next;
            led     <= ONE << idx_next;
          end else if (hit) begin
            hit_ok <= 1'b1;
          end
        end
        CHECK: begin
          if (lose) begin
            state     <= LOST;
            game_over <= 1'b1;
            led       <= ONES;
          end else if (score == WIN_SCORE) begin
            state <= WON;
            won   <= 1'b1;
            led   <= alt_pat;
          end else begin
            state <= PLAY;
            led   <= ONE << led_idx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blink_game_ctrl.sv
// Directed bench for blink_game_ctrl with a small loss-detector model
// (lose is visible in the enable cycle and sticky until dec_rst).
module tb_blink_game_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, hit, lose;
  logic       dec_d, dec_enable, dec_rst, game_over, won;
  logic [3:0] led;
  logic [3:0] score;
  logic       lose_q;
  int         checks = 0;
  int         errors = 0;

  blink_game_ctrl #(
    .TICK_DIV (4),
    .N_LEDS   (4),
    .WIN_HITS (2),
    .ARM_TICKS(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .hit       (hit),
    .lose      (lose),
    .dec_d     (dec_d),
    .dec_enable(dec_enable),
    .dec_rst   (dec_rst),
    .led       (led),
    .score     (score),
    .game_over (game_over),
    .won       (won)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset)                    lose_q <= 1'b0;
    else if (dec_rst)             lose_q <= 1'b0;
    else if (dec_enable && !dec_d) lose_q <= 1'b1;
  end
  assign lose = lose_q | (dec_enable & ~dec_d);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_led(input logic [3:0] v, input int max);
    int n = 0;
    while (led !== v && n < max) begin
      step();
      n++;
    end
    chk("wait_led", 32'(led), 32'(v));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hit = 1'b0;
    step(); step();
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_score", 32'(score), 32'h0);
    chk("rst_en", 32'(dec_enable), 32'h0);
    chk("rst_drst", 32'(dec_rst), 32'h0);
    chk("rst_over", 32'(game_over), 32'h0);
    chk("rst_won", 32'(won), 32'h0);
    reset = 1'b0;
    step();

    // 1: arm countdown
    pulse_start();
    chk("arm_drst", 32'(dec_rst), 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("arm_on", 32'(led), 32'hF);
      if (i == 1) chk("drst_once", 32'(dec_rst), 32'h0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      chk("arm_off", 32'(led), 32'h0);
      step();
    end
    chk("play_led", 32'(led), 32'h1);

    // 2: two successful windows -> WON
    for (int w = 0; w < 2; w++) begin
      wait_led(4'h8, 40);
      hit = 1'b1; step(); hit = 1'b0;
      step(); step(); step();
      chk("win_en", 32'(dec_enable), 32'h1);
      chk("win_d", 32'(dec_d), 32'h1);
      chk("win_score", 32'(score), 32'(w + 1));
      step();
      if (w == 0) chk("en_pulse", 32'(dec_enable), 32'h0);
    end
    chk("won", 32'(won), 32'h1);
    chk("won_led", 32'(led), 32'hA);
    chk("won_over", 32'(game_over), 32'h0);

    // 3: missed window -> LOST
    pulse_start();
    chk("rs_drst", 32'(dec_rst), 32'h1);
    chk("rs_score", 32'(score), 32'h0);
    chk("rs_won", 32'(won), 32'h0);
    wait_led(4'h1, 40);
    wait_led(4'h8, 40);
    step(); step(); step(); step();
    chk("miss_en", 32'(dec_enable), 32'h1);
    chk("miss_d", 32'(dec_d), 32'h0);
    step();
    chk("miss_over", 32'(game_over), 32'h1);
    chk("miss_led", 32'(led), 32'hF);
    chk("miss_score", 32'(score), 32'h0);

    // 4: wrong hit -> LOST
    pulse_start();
    wait_led(4'h1, 40);
    wait_led(4'h2, 40);
    hit = 1'b1; step(); hit = 1'b0;
    chk("wrong_en", 32'(dec_enable), 32'h1);
    chk("wrong_d", 32'(dec_d), 32'h0);
    step();
    chk("wrong_over", 32'(game_over), 32'h1);

    // 5: hit on closing tick, then double hit in one window
    pulse_start();
    wait_led(4'h1, 40);
    wait_led(4'h8, 40);
    step(); step(); step();
    hit = 1'b1; step(); hit = 1'b0;
    chk("edge_d", 32'(dec_d), 32'h1);
    chk("edge_score", 32'(score), 32'h1);
    step();
    wait_led(4'h8, 40);
    hit = 1'b1; step(); step(); hit = 1'b0;
    step(); step();
    chk("dbl_en", 32'(dec_enable), 32'h1);
    chk("dbl_score", 32'(score), 32'h2);
    step();
    chk("dbl_won", 32'(won), 32'h1);

    // 6: start ignored in PLAY, async reset mid-PLAY
    pulse_start();
    chk("r6_drst", 32'(dec_rst), 32'h1);
    chk("r6_won", 32'(won), 32'h0);
    wait_led(4'h1, 40);
    pulse_start();
    chk("ign_drst", 32'(dec_rst), 32'h0);
    chk("ign_led", 32'(led), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("arst_led", 32'(led), 32'h0);
    chk("arst_all", 32'({dec_d, dec_enable, dec_rst, game_over, won, score}), 32'h0);
    step();
    reset = 1'b0;
    step();
    chk("idle_led", 32'(led), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
